sensors: RTL and testbench

SENSORS -- requirements
Module: sensors

---
 rtl/sensors_if.sv | 21 ++
 rtl/sensors.sv | 113 +++++++++++
 tb/tb_sensors.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sensors_if.sv
// Signal bundle between the thermal sensor model and its user: load/fan
// controls and LFSR seed in, temperature, overheat, tick and LFSR state out.
interface sensors_if;
    logic        in_use;
    logic [1:0]  fan_speed;
    logic [31:0] seed;
    logic [7:0]  temp;
    logic        overheat;
    logic        tick;
    logic [31:0] rand_val;

    modport dut (
        input  in_use,
        input  fan_speed,
        input  seed,
        output temp,
        output overheat,
        output tick,
        output rand_val
    );
endinterface

// File: rtl/sensors.sv
// Thermal sensor model: every UPDATE_PERIOD clocks the temperature moves by
// a load/fan dependent step plus optional LFSR noise, clamped to
// [AMBIENT, TEMP_MAX], with a registered overheat flag and a tick pulse.
module sensors #(
    parameter int UPDATE_PERIOD = 10,
    parameter int AMBIENT       = 25,
    parameter int TEMP_MAX      = 100,
    parameter int OVERHEAT_TH   = 85,
    parameter int NOISE_EN      = 1
) (
    input logic    CLK,
    input logic    nRST,
    sensors_if.dut sif
);

    localparam int                 CNT_W     = (UPDATE_PERIOD > 2) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(UPDATE_PERIOD - 1);
    localparam logic [31:0]        LFSR_TAPS = 32'h8020_0003;
    localparam logic signed [9:0]  AMB_S     = 10'(AMBIENT);
    localparam logic signed [9:0]  MAX_S     = 10'(TEMP_MAX);
    localparam logic [7:0]         AMB_U     = 8'(AMBIENT);
    localparam logic [7:0]         TH_U      = 8'(OVERHEAT_TH);

    logic [CNT_W-1:0]  cnt;
    logic              upd;
    logic              seeded;
    logic [31:0]       lfsr;
    logic [31:0]       lfsr_next;
    logic [7:0]        temp_q;
    logic              ovh_q;
    logic              tick_q;
    logic signed [9:0] noise;
    logic signed [9:0] delta;
    logic signed [9:0] temp_sum;
    logic [7:0]        temp_next;

    // Map the two low LFSR bits onto a -1/0/0/+1 noise step.
    function automatic logic signed [9:0] noise_of(input logic [1:0] bits);
        logic signed [9:0] n;
        case (bits)
            2'b00:   n = -10'sd1;
            2'b11:   n = 10'sd1;
            default: n = 10'sd0;
        endcase
        return n;
    endfunction

    // Saturate a signed candidate temperature into [AMBIENT, TEMP_MAX].
    function automatic logic [7:0] clamp_temp(input logic signed [9:0] v);
        logic [7:0] r;
        if (v < AMB_S)
            r = AMB_U;
        else if (v > MAX_S)
            r = 8'(TEMP_MAX);
        else
            r = v[7:0];
        return r;
    endfunction

    assign upd = (cnt == CNT_LAST);

    // Next LFSR state, temperature step and clamped next temperature.
    always_comb begin
        lfsr_next = {1'b0, lfsr[31:1]};
        if (lfsr[0])
            lfsr_next = {1'b0, lfsr[31:1]} ^ LFSR_TAPS;
        noise = (NOISE_EN != 0) ? noise_of(lfsr[1:0]) : 10'sd0;
        delta = (sif.in_use ? 10'sd4 : -10'sd1) - $signed({8'd0, sif.fan_speed}) + noise;
        temp_sum  = $signed({2'b00, temp_q}) + delta;
        temp_next = clamp_temp(temp_sum);
    end

    // Update-period counter; tick marks the cycle after each wrap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt    <= upd ? '0 : cnt + 1'b1;
            tick_q <= upd;
        end
    end

    // LFSR: loaded from the seed on the first edge after reset, then stepped.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lfsr   <= '0;
            seeded <= 1'b0;
        end else if (!seeded) begin
            lfsr   <= (sif.seed == 32'd0) ? 32'd1 : sif.seed;
            seeded <= 1'b1;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // Temperature and overheat flag change only on update edges.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            temp_q <= AMB_U;
            ovh_q  <= 1'b0;
        end else if (upd) begin
            temp_q <= temp_next;
            ovh_q  <= (temp_next >= TH_U);
        end
    end

    assign sif.temp     = temp_q;
    assign sif.overheat = ovh_q;
    assign sif.tick     = tick_q;
    assign sif.rand_val = lfsr;

endmodule

// File: tb/tb_sensors.sv
// Bench for sensors: a noise-free instance driven with directed load/fan
// sequences and a noisy instance driven with random inputs, both checked
// every cycle against an edge-counting reference model.
module tb_sensors;

    localparam int P      = 10;
    localparam int AMB    = 25;
    localparam int TMAX   = 100;
    localparam int TH     = 85;

    logic CLK;
    logic nRST;

    sensors_if s0 ();
    sensors_if s1 ();

    sensors #(.UPDATE_PERIOD(P), .AMBIENT(AMB), .TEMP_MAX(TMAX), .OVERHEAT_TH(TH), .NOISE_EN(0))
        dut0 (.CLK(CLK), .nRST(nRST), .sif(s0));
    sensors #(.UPDATE_PERIOD(P), .AMBIENT(AMB), .TEMP_MAX(TMAX), .OVERHEAT_TH(TH), .NOISE_EN(1))
        dut1 (.CLK(CLK), .nRST(nRST), .sif(s1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: edges since reset release, per-instance state.
    int          m_edges;
    int          m_temp   [2];
    bit          m_ovh    [2];
    bit          m_tick   [2];
    logic [31:0] m_lfsr   [2];
    bit          m_seeded [2];
    int          tick_cnt;
    bit          bias_hot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_edges = 0;
        for (int k = 0; k < 2; k++) begin
            m_temp[k]   = AMB;
            m_ovh[k]    = 1'b0;
            m_tick[k]   = 1'b0;
            m_lfsr[k]   = 32'd0;
            m_seeded[k] = 1'b0;
        end
    endtask

    // One rising edge for one instance, using the inputs present at the edge.
    task automatic model_one(input int k, input bit iu, input int fs,
                             input logic [31:0] sd, input bit nz);
        logic [31:0] old;
        int n, t;
        old = m_lfsr[k];
        if (!m_seeded[k]) begin
            m_lfsr[k]   = (sd == 0) ? 32'd1 : sd;
            m_seeded[k] = 1'b1;
        end else if (old % 2 == 1) begin
            m_lfsr[k] = (old / 2) ^ 32'h8020_0003;
        end else begin
            m_lfsr[k] = old / 2;
        end
        m_tick[k] = 1'b0;
        if (m_edges % P == 0) begin
            n = 0;
            if (nz) begin
                if (old % 4 == 0) n = -1;
                else if (old % 4 == 3) n = 1;
            end
            t = m_temp[k] + (iu ? 4 : -1) - fs + n;
            if (t < AMB) t = AMB;
            if (t > TMAX) t = TMAX;
            m_temp[k] = t;
            m_ovh[k]  = (t >= TH);
            m_tick[k] = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("d0_temp", 32'(s0.temp), 32'(m_temp[0]));
        chk("d0_overheat", 32'(s0.overheat), 32'(m_ovh[0]));
        chk("d0_tick", 32'(s0.tick), 32'(m_tick[0]));
        chk("d0_rand", s0.rand_val, m_lfsr[0]);
        chk("d1_temp", 32'(s1.temp), 32'(m_temp[1]));
        chk("d1_overheat", 32'(s1.overheat), 32'(m_ovh[1]));
        chk("d1_tick", 32'(s1.tick), 32'(m_tick[1]));
        chk("d1_rand", s1.rand_val, m_lfsr[1]);
        chk("d1_range", 32'((s1.temp >= 8'd25) && (s1.temp <= 8'd100)), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_temp0"}, 32'(s0.temp), 32'd25);
        chk({tag, "_ovh0"}, 32'(s0.overheat), 32'd0);
        chk({tag, "_tick0"}, 32'(s0.tick), 32'd0);
        chk({tag, "_rand0"}, s0.rand_val, 32'd0);
        chk({tag, "_temp1"}, 32'(s1.temp), 32'd25);
        chk({tag, "_rand1"}, s1.rand_val, 32'd0);
    endtask

    // Advance n clock edges; model, compare, then re-randomize dut1 inputs.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            m_edges++;
            model_one(0, s0.in_use, int'(s0.fan_speed), s0.seed, 1'b0);
            model_one(1, s1.in_use, int'(s1.fan_speed), s1.seed, 1'b1);
            #1;
            check_all();
            if (s0.tick) tick_cnt++;
            @(negedge CLK);
            s1.in_use    = bias_hot ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            s1.fan_speed = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        bias_hot     = 1'b0;
        tick_cnt     = 0;
        nRST         = 1'b0;
        s0.in_use    = 1'b1;
        s0.fan_speed = 2'd0;
        s0.seed      = 32'd35;
        s1.in_use    = 1'b0;
        s1.fan_speed = 2'd0;
        s1.seed      = 32'd35;
        model_reset();

        // Held in reset for ten cycles.
        repeat (10) @(posedge CLK);
        #1;
        check_reset_vals("rst");

        // Release, then heat at full load with the fan off.
        @(negedge CLK);
        nRST = 1'b1;
        step(1);
        chk("seed_load0", s0.rand_val, 32'h23);
        chk("seed_load1", s1.rand_val, 32'h23);
        step(99);
        chk("ticks_100", 32'(tick_cnt), 32'd10);
        chk("temp_100", 32'(s0.temp), 32'd65);
        step(40);
        chk("temp_140", 32'(s0.temp), 32'd81);
        chk("ovh_140", 32'(s0.overheat), 32'd0);
        step(10);
        chk("temp_150", 32'(s0.temp), 32'd85);
        chk("ovh_150", 32'(s0.overheat), 32'd1);
        step(30);
        chk("temp_180", 32'(s0.temp), 32'd97);
        step(10);
        chk("temp_190_sat", 32'(s0.temp), 32'd100);
        step(10);
        chk("temp_200_sat", 32'(s0.temp), 32'd100);

        // Cool down with the fan at max until overheat drops.
        s0.in_use    = 1'b0;
        s0.fan_speed = 2'd3;
        step(39);
        chk("temp_239", 32'(s0.temp), 32'd88);
        chk("ovh_239", 32'(s0.overheat), 32'd1);
        step(1);
        chk("temp_240", 32'(s0.temp), 32'd84);
        chk("ovh_240", 32'(s0.overheat), 32'd0);
        step(5);

        // Counter now at 5: pulse reset for one cycle mid-period.
        nRST = 1'b0;
        model_reset();
        #1;
        check_reset_vals("midrst");
        s1.seed      = 32'd0;
        s0.in_use    = 1'b1;
        s0.fan_speed = 2'd3;
        @(negedge CLK);
        nRST = 1'b1;
        step(1);
        chk("seed_zero", s1.rand_val, 32'd1);
        chk("reseed0", s0.rand_val, 32'h23);
        step(8);
        chk("tick_e9", 32'(s0.tick), 32'd0);
        step(1);
        chk("tick_e10", 32'(s0.tick), 32'd1);

        // Light load with fan at max, then idle down to the ambient clamp.
        step(90);
        chk("temp_fan3_load", 32'(s0.temp), 32'd35);
        s0.in_use = 1'b0;
        step(10);
        chk("temp_cool1", 32'(s0.temp), 32'd31);
        step(10);
        chk("temp_cool2", 32'(s0.temp), 32'd27);
        step(10);
        chk("temp_clamp1", 32'(s0.temp), 32'd25);
        step(20);
        chk("temp_clamp2", 32'(s0.temp), 32'd25);

        // Push the noisy instance hot to exercise its upper clamp.
        bias_hot = 1'b1;
        step(400);
        bias_hot = 1'b0;
        step(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
